// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// The state enum is visible to anything that binds checkers to the loader FSM.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

    localparam int LEN_BYTES         = 2;
    localparam int CSUM_WIDTH        = 8;
    localparam int DEFAULT_MAX_WORDS = 8192;

    // States from which a start pulse may begin a new load.
    function automatic logic is_rest_state(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and word write port out of the program loader.
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready; the source holds rx_valid/rx_data until then.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted bytes, least-significant first, into 32-bit words.
// word_valid fires combinationally with the fourth byte so the caller can register the write.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  lane;
    logic [23:0] low_bytes;

    assign word_valid = byte_valid && (lane == 2'd3);
    assign word_data  = {byte_data, low_bytes};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane      <= 2'd0;
            low_bytes <= 24'd0;
        end else if (byte_valid) begin
            lane      <= lane + 2'd1;
            low_bytes <= {byte_data, low_bytes[23:8]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, checksummed byte image into the combined memory
// and keeps the core in reset until the image has been verified.
module prog_loader
    import riscv_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WORDS  = DEFAULT_MAX_WORDS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          core_reset,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded,
    output loader_state_t dbg_state
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    loader_state_t                 state;
    logic [8*LEN_BYTES-1:0]        len;
    logic [8*LEN_BYTES-1:0]        len_n;
    logic [CSUM_WIDTH-1:0]         sum;
    logic                          accept;
    logic                          restart;
    logic                          word_valid;
    logic [31:0]                   word_data;

    assign bus.rx_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                          (state == ST_DATA)   || (state == ST_CSUM);
    assign accept    = bus.rx_valid && bus.rx_ready;
    assign restart   = start && is_rest_state(state);
    assign len_n     = {bus.rx_data, len[7:0]};
    assign dbg_state = state;

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            len           <= '0;
            sum           <= '0;
            words_loaded  <= 16'd0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            core_reset    <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state        <= ST_LEN_LO;
                        sum          <= '0;
                        words_loaded <= 16'd0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_reset   <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= bus.rx_data;
                        state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len <= len_n;
                        if ({1'b0, len_n} > MAX_N) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else if (len_n == '0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        sum <= sum + bus.rx_data;
                        if (word_valid) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= words_loaded[ADDR_WIDTH-1:0];
                            bus.mem_wdata <= word_data;
                            words_loaded  <= words_loaded + 16'd1;
                            if (words_loaded + 16'd1 == len) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        // Words already written stay in memory on a bad checksum.
                        if (bus.rx_data == sum) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized checks of prog_loader against a byte-stream reference model.
module tb_prog_loader;
    import riscv_loader_pkg::*;

    localparam int AW   = 14;
    localparam int MAXW = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_reset;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;
    loader_state_t dbg_state;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]    data_q[$];
    logic [7:0]    stream_q[$];
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   cap_data_q[$];
    logic [AW-1:0] cap_addr_q[$];

    prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

    prog_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Write monitor: every cycle with mem_we high is one write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            cap_addr_q.push_back(bus.mem_addr);
            cap_data_q.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: image = header, data bytes, 8-bit sum of data bytes.
    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < n * 4; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic make_stream(input int n_hdr, input bit corrupt);
        int unsigned total;
        int unsigned w;
        stream_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        cap_data_q.delete();
        cap_addr_q.delete();
        stream_q.push_back(8'(n_hdr % 256));
        stream_q.push_back(8'(n_hdr / 256));
        total = 0;
        foreach (data_q[i]) begin
            stream_q.push_back(data_q[i]);
            total += data_q[i];
        end
        for (int i = 0; i < data_q.size() / 4; i++) begin
            w = data_q[4*i] + 256 * data_q[4*i+1] + 65536 * data_q[4*i+2] + 16777216 * data_q[4*i+3];
            exp_q.push_back(w);
            exp_addr_q.push_back(AW'(i));
        end
        stream_q.push_back(8'((total + (corrupt ? 1 : 0)) % 256));
    endtask

    // Driver tasks
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        bit ok;
        g  = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        ok = 1'b0;
        if (g > 0) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom_range(0, 255));
            repeat (g) begin @(posedge clk); #1; end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("byte_timeout_rx_ready", 32'(bus.rx_ready), 32'd1);
        else begin @(posedge clk); #1; end
    endtask

    task automatic send_stream(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) send_byte(stream_q[i], gap_max);
        bus.rx_valid = 1'b0;
    endtask

    // Scoreboard
    task automatic check_writes(input string tag);
        check({tag, "_wcount"}, 32'(cap_data_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_data_q.size(); i++) begin
            check({tag, "_waddr"}, 32'(cap_addr_q[i]), 32'(exp_addr_q[i]));
            check({tag, "_wdata"}, cap_data_q[i], exp_q[i]);
        end
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err, input int exp_wl);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(!exp_done));
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_wl));
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic load_nominal_data();
        data_q = '{8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h30, 8'h00};
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("reset");

        // rx_valid while idle must not be consumed
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (3) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b0;
        check("idle_no_accept_state", 32'(dbg_state), 32'(ST_IDLE));

        // Nominal image
        load_nominal_data();
        make_stream(2, 1'b0);
        check("nom_csum_byte", 32'(stream_q[10]), 32'h2B);
        start_pulse();
        send_stream(0, stream_q.size() - 1, 0);
        check_status("nom", 1'b1, 1'b0, 2);
        check_writes("nom");
        check("nom_w0_const", cap_data_q.size() > 0 ? cap_data_q[0] : 32'hDEAD_BEEF, 32'h00500293);
        check("nom_w1_const", cap_data_q.size() > 1 ? cap_data_q[1] : 32'hDEAD_BEEF, 32'h00300313);

        // Bad checksum
        load_nominal_data();
        make_stream(2, 1'b1);
        start_pulse();
        send_stream(0, stream_q.size() - 1, 0);
        check_status("badsum", 1'b0, 1'b1, 2);
        check_writes("badsum");

        // Empty image
        data_q.delete();
        make_stream(0, 1'b0);
        start_pulse();
        send_stream(0, stream_q.size() - 1, 0);
        check_status("n0", 1'b1, 1'b0, 0);
        check_writes("n0");

        // Length one above the limit
        data_q.delete();
        make_stream(MAXW + 1, 1'b0);
        start_pulse();
        send_stream(0, 1, 0);
        check_status("over", 1'b0, 1'b1, 0);
        check("over_state", 32'(dbg_state), 32'(ST_ERROR));
        check_writes("over");

        // Backpressure gaps on the nominal stream
        load_nominal_data();
        make_stream(2, 1'b0);
        start_pulse();
        send_stream(0, stream_q.size() - 1, 3);
        check_status("gaps", 1'b1, 1'b0, 2);
        check_writes("gaps");

        // Randomized images
        for (int it = 0; it < 6; it++) begin
            int n;
            bit bad;
            n   = $urandom_range(1, 12);
            bad = ($urandom_range(0, 3) == 0);
            fill_random(n);
            make_stream(n, bad);
            start_pulse();
            send_stream(0, stream_q.size() - 1, 2);
            check_status("rand", !bad, bad, n);
            check_writes("rand");
        end

        // Reset in the middle of DATA
        load_nominal_data();
        make_stream(2, 1'b0);
        start_pulse();
        send_stream(0, 5, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("midreset");
        check("midreset_wcount", 32'(cap_data_q.size()), 32'd1);
        check("midreset_w0", cap_data_q.size() > 0 ? cap_data_q[0] : 32'hDEAD_BEEF, 32'h00500293);
        make_stream(2, 1'b0);
        start_pulse();
        send_stream(0, stream_q.size() - 1, 1);
        check_status("after_reset", 1'b1, 1'b0, 2);
        check_writes("after_reset");

        // Restart from DONE, with a start pulse during DATA ignored
        fill_random(3);
        make_stream(3, 1'b0);
        start_pulse();
        check("restart_core_reset", 32'(core_reset), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("restart_words_loaded", 32'(words_loaded), 32'd0);
        send_stream(0, 3, 0);
        start_pulse();
        check("ignored_start_state", 32'(dbg_state), 32'(ST_DATA));
        send_stream(4, stream_q.size() - 1, 1);
        check_status("restart", 1'b1, 1'b0, 3);
        check_writes("restart");

        // Reset and start together from DONE: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check_reset_values("reset_vs_start");

        // Largest accepted image
        fill_random(MAXW);
        make_stream(MAXW, 1'b0);
        start_pulse();
        send_stream(0, stream_q.size() - 1, 0);
        check_status("maxw", 1'b1, 1'b0, MAXW);
        check_writes("maxw");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
